// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared state encoding and defaults for the SPI transfer controller
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } xfer_state_t;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MAX_BYTES   = 4096;

endpackage

// File: rtl/spi_ss_sync.sv
// rtl/spi_ss_sync.sv - SPI_SS synchroniser with registered fall/rise pulse detector
module spi_ss_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_raw,
  output logic ss_fall,
  output logic ss_rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [SYNC_STAGES:0]   vld;
  logic                   ss_s;

  assign ss_s = sync[SYNC_STAGES-1];

  // vld masks edges until the chain and prev both hold real pad samples,
  // so a chip select already low at reset release is not seen as a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '1;
      prev    <= 1'b1;
      vld     <= '0;
      ss_fall <= 1'b0;
      ss_rise <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], ss_raw};
      vld     <= {vld[SYNC_STAGES-1:0], 1'b1};
      prev    <= ss_s;
      ss_fall <= vld[SYNC_STAGES] & prev & ~ss_s;
      ss_rise <= vld[SYNC_STAGES] & ~prev & ss_s;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI slave transfer sequencer with ping-pong bank control and host handshake
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MAX_BYTES   = DEF_MAX_BYTES
) (
  input  logic            SysClk,
  input  logic            Reset,
  input  logic            SPI_SS,
  input  logic            rcMemWE,
  input  logic            hostArm,
  input  logic            hostAck,
  output logic            armed,
  output logic            ssActive,
  output logic            xferDone,
  output logic [ADDR_W:0] xferLen,
  output logic            xferOverflow,
  output logic            xferDropped,
  output logic            rcBank,
  output logic            txBank,
  output logic [1:0]      state
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_BYTES);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  xfer_state_t     st;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] cnt_upd;
  logic            at_max;
  logic            ss_fall;
  logic            ss_rise;

  spi_ss_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ss_sync (
    .clk    (SysClk),
    .rst_n  (Reset),
    .ss_raw (SPI_SS),
    .ss_fall(ss_fall),
    .ss_rise(ss_rise)
  );

  // A strobe coincident with ss_rise must land in xferLen, so the load uses cnt_upd.
  assign at_max  = (cnt == MAX_CNT);
  assign cnt_upd = (rcMemWE && !at_max) ? cnt + CNT_ONE : cnt;
  assign state   = st;

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      st           <= IDLE;
      cnt          <= '0;
      armed        <= 1'b0;
      ssActive     <= 1'b0;
      xferDone     <= 1'b0;
      xferLen      <= '0;
      xferOverflow <= 1'b0;
      xferDropped  <= 1'b0;
      rcBank       <= 1'b0;
      txBank       <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (hostArm) begin
            st          <= ARMED;
            armed       <= 1'b1;
            txBank      <= ~txBank;
            xferDropped <= 1'b0;
          end else if (ss_fall) begin
            xferDropped <= 1'b1;
          end
        end
        ARMED: begin
          if (ss_fall) begin
            st           <= ACTIVE;
            armed        <= 1'b0;
            ssActive     <= 1'b1;
            cnt          <= '0;
            xferOverflow <= 1'b0;
          end
        end
        ACTIVE: begin
          cnt <= cnt_upd;
          if (rcMemWE && at_max) xferOverflow <= 1'b1;
          if (ss_rise) begin
            st       <= DONE;
            ssActive <= 1'b0;
            xferDone <= 1'b1;
            xferLen  <= cnt_upd;
            rcBank   <= ~rcBank;
          end
        end
        DONE: begin
          if (ss_fall) xferDropped <= 1'b1;
          if (hostAck) begin
            xferDone <= 1'b0;
            if (hostArm) begin
              st     <= ARMED;
              armed  <= 1'b1;
              txBank <= ~txBank;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
